// File: rtl/flappy_pkg.sv
// ---------------------------------------------------------------------------
// | flappy_pkg                                                              |
// | Shared state encoding and screen geometry for the flappy datapath.      |
// | Rev 1.0                                                                 |
// ---------------------------------------------------------------------------
`default_nettype none

package flappy_pkg;

  localparam int COORD_W  = 10;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef enum logic [2:0] {
    S_IDLE   = 3'b001,
    S_RUN    = 3'b010,
    S_FROZEN = 3'b100
  } state_t;

endpackage

`default_nettype wire

// File: rtl/pipe_lfsr.sv
// ---------------------------------------------------------------------------
// | pipe_lfsr                                                               |
// | Free-running 10-bit Fibonacci LFSR, polynomial x^10 + x^7 + 1.          |
// | Rev 1.0                                                                 |
// ---------------------------------------------------------------------------
`default_nettype none

module pipe_lfsr #(
  parameter logic [9:0] SEED = 10'h2A5
) (
  input  logic       Clk,
  input  logic       reset_n,
  output logic [9:0] o_value
);

  logic [9:0] r_lfsr;

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lfsr <= SEED;
    end else begin
      r_lfsr <= {r_lfsr[8:0], r_lfsr[9] ^ r_lfsr[6]};
    end
  end

  assign o_value = r_lfsr;

endmodule

`default_nettype wire

// File: rtl/pipe_scheduler.sv
// ---------------------------------------------------------------------------
// | pipe_scheduler                                                          |
// | Scrolls a ring of pipe slots, selects the in-scope pipe and keeps score.|
// | Rev 1.0                                                                 |
// ---------------------------------------------------------------------------
`default_nettype none

module pipe_scheduler #(
  parameter int         NUM_PIPES = 3,
  parameter int         PIPE_W    = 60,
  parameter int         GAP_H     = 120,
  parameter int         SPACING   = 240,
  parameter int         SCREEN_W  = 640,
  parameter int         SPEED     = 2,
  parameter int         GAP_MIN   = 80,
  parameter int         GAP_INIT  = 180,
  parameter logic [9:0] LFSR_SEED = 10'h2A5
) (
  input  logic                           Clk,
  input  logic                           reset_n,
  input  logic                           Start,
  input  logic                           Tick,
  input  logic                           Lose,
  input  logic                           Ack,
  input  logic [flappy_pkg::COORD_W-1:0] Bird_X_L,
  output logic [flappy_pkg::COORD_W-1:0] X_Edge_Left,
  output logic [flappy_pkg::COORD_W-1:0] X_Edge_Right,
  output logic [flappy_pkg::COORD_W-1:0] Y_Edge_Top,
  output logic [flappy_pkg::COORD_W-1:0] Y_Edge_Bottom,
  output logic [7:0]                     Score,
  output logic                           Score_Tick,
  output logic                           Q_Idle,
  output logic                           Q_Run,
  output logic                           Q_Frozen
);

  import flappy_pkg::*;

  localparam int          c_hw       = $clog2(NUM_PIPES);
  localparam logic [10:0] c_speed    = 11'(SPEED);
  localparam logic [10:0] c_wrap     = 11'(NUM_PIPES * SPACING - SPEED);
  localparam logic [10:0] c_pipe_w   = 11'(PIPE_W);
  localparam logic [10:0] c_x_max    = 11'd1023;
  localparam logic [9:0]  c_gap_min  = 10'(GAP_MIN);
  localparam logic [9:0]  c_gap_h    = 10'(GAP_H);
  localparam logic [9:0]  c_gap_init = 10'(GAP_INIT);
  localparam logic [c_hw-1:0] c_head_last = c_hw'(NUM_PIPES - 1);

  function automatic logic [10:0] init_xr(input int idx);
    return 11'(SCREEN_W + PIPE_W + idx * SPACING);
  endfunction

  state_t          r_state;
  logic [10:0]     r_xr [NUM_PIPES];
  logic [9:0]      r_gt [NUM_PIPES];
  logic [c_hw-1:0] r_head;
  logic [7:0]      r_score;
  logic            r_score_tick;

  logic [9:0]      w_lfsr;
  logic [9:0]      w_new_gap;
  logic [10:0]     w_head_xr;
  logic [10:0]     w_left_raw;
  logic            w_load_init;
  logic            w_move;
  logic            w_pass;
  logic [c_hw-1:0] w_head_next;
  logic            w_unused;

  pipe_lfsr #(
    .SEED    (LFSR_SEED)
  ) u_lfsr (
    .Clk     (Clk),
    .reset_n (reset_n),
    .o_value (w_lfsr)
  );

  assign w_unused    = &{1'b0, w_lfsr[9:8]};
  assign w_new_gap   = c_gap_min + {2'b00, w_lfsr[7:0]};
  assign w_head_xr   = r_xr[r_head];
  assign w_load_init = (r_state == S_IDLE) || ((r_state == S_FROZEN) && Ack);
  assign w_move      = (r_state == S_RUN) && Tick && !Lose;
  assign w_pass      = (r_state == S_RUN) && !Lose && (w_head_xr < {1'b0, Bird_X_L});
  assign w_head_next = (r_head == c_head_last) ? '0 : r_head + 1'b1;

  // A slot at or below SPEED wraps by a full ring length so spacing stays exact.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_PIPES; i++) begin
        r_xr[i] <= init_xr(i);
        r_gt[i] <= c_gap_init;
      end
    end else if (w_load_init) begin
      for (int i = 0; i < NUM_PIPES; i++) begin
        r_xr[i] <= init_xr(i);
        r_gt[i] <= c_gap_init;
      end
    end else if (w_move) begin
      for (int i = 0; i < NUM_PIPES; i++) begin
        if (r_xr[i] <= c_speed) begin
          r_xr[i] <= r_xr[i] + c_wrap;
          r_gt[i] <= w_new_gap;
        end else begin
          r_xr[i] <= r_xr[i] - c_speed;
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_head       <= '0;
      r_score      <= 8'd0;
      r_score_tick <= 1'b0;
    end else begin
      r_score_tick <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_head <= '0;
          if (Start) begin
            r_state <= S_RUN;
            r_score <= 8'd0;
          end
        end
        S_RUN: begin
          if (Lose) begin
            r_state <= S_FROZEN;
          end else if (w_pass) begin
            r_head       <= w_head_next;
            r_score_tick <= 1'b1;
            if (r_score != 8'hFF) begin
              r_score <= r_score + 8'd1;
            end
          end
        end
        S_FROZEN: begin
          if (Ack) begin
            r_state <= S_IDLE;
            r_head  <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_left_raw    = (w_head_xr >= c_pipe_w) ? (w_head_xr - c_pipe_w) : 11'd0;
  assign X_Edge_Right  = (w_head_xr  > c_x_max) ? 10'd1023 : w_head_xr[9:0];
  assign X_Edge_Left   = (w_left_raw > c_x_max) ? 10'd1023 : w_left_raw[9:0];
  assign Y_Edge_Top    = r_gt[r_head];
  assign Y_Edge_Bottom = r_gt[r_head] + c_gap_h;
  assign Score         = r_score;
  assign Score_Tick    = r_score_tick;
  assign Q_Idle        = (r_state == S_IDLE);
  assign Q_Run         = (r_state == S_RUN);
  assign Q_Frozen      = (r_state == S_FROZEN);

endmodule

`default_nettype wire

// File: tb/tb_pipe_scheduler.sv
// ---------------------------------------------------------------------------
// | tb_pipe_scheduler                                                       |
// | Randomized self-checking bench for pipe_scheduler against a model.      |
// | Rev 1.0                                                                 |
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pipe_scheduler;

  logic       Clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start_a = 0, tick_a = 0, lose_a = 0, ack_a = 0;
  logic       start_b = 0, tick_b = 0, lose_b = 0, ack_b = 0;
  logic [9:0] bird_a = 10'd100, bird_b = 10'd200;
  logic [9:0] xl_a, xr_a, yt_a, yb_a, xl_b, xr_b, yt_b, yb_b;
  logic [7:0] score_a, score_b;
  logic       stick_a, stick_b, qi_a, qr_a, qf_a, qi_b, qr_b, qf_b;

  int checks = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  pipe_scheduler dut (
    .Clk(Clk), .reset_n(reset_n), .Start(start_a), .Tick(tick_a), .Lose(lose_a), .Ack(ack_a),
    .Bird_X_L(bird_a), .X_Edge_Left(xl_a), .X_Edge_Right(xr_a), .Y_Edge_Top(yt_a),
    .Y_Edge_Bottom(yb_a), .Score(score_a), .Score_Tick(stick_a),
    .Q_Idle(qi_a), .Q_Run(qr_a), .Q_Frozen(qf_a)
  );

  pipe_scheduler #(.SPEED(120)) dut_b (
    .Clk(Clk), .reset_n(reset_n), .Start(start_b), .Tick(tick_b), .Lose(lose_b), .Ack(ack_b),
    .Bird_X_L(bird_b), .X_Edge_Left(xl_b), .X_Edge_Right(xr_b), .Y_Edge_Top(yt_b),
    .Y_Edge_Bottom(yb_b), .Score(score_b), .Score_Tick(stick_b),
    .Q_Idle(qi_b), .Q_Run(qr_b), .Q_Frozen(qf_b)
  );

  wire [51:0] act_a = {xr_a, xl_a, yt_a, yb_a, score_a, stick_a, qi_a, qr_a, qf_a};
  wire [51:0] act_b = {xr_b, xl_b, yt_b, yb_b, score_b, stick_b, qi_b, qr_b, qf_b};

  // Reference model: game state 0 idle, 1 run, 2 frozen; plain integer pixel positions.
  int m_x [2][3];
  int m_g [2][3];
  int m_head [2];
  int m_score [2];
  int m_stick [2];
  int m_st [2];
  int m_lfsr [2];
  int m_speed [2];

  task automatic model_init(input int k);
    for (int i = 0; i < 3; i++) begin
      m_x[k][i] = 700 + i * 240;
      m_g[k][i] = 180;
    end
    m_head[k] = 0;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      model_init(k);
      m_score[k] = 0;
      m_stick[k] = 0;
      m_st[k]    = 0;
      m_lfsr[k]  = 'h2A5;
    end
  endtask

  task automatic model_clk(input int k, input bit st, input bit tk, input bit lo,
                           input bit ak, input int bx);
    int nl;
    bit pass;
    nl = ((m_lfsr[k] << 1) & 1023) | (((m_lfsr[k] >> 9) ^ (m_lfsr[k] >> 6)) & 1);
    m_stick[k] = 0;
    if (m_st[k] == 0) begin
      model_init(k);
      if (st) begin
        m_st[k]    = 1;
        m_score[k] = 0;
      end
    end else if (m_st[k] == 1) begin
      if (lo) begin
        m_st[k] = 2;
      end else begin
        pass = m_x[k][m_head[k]] < bx;
        if (tk) begin
          for (int i = 0; i < 3; i++) begin
            if (m_x[k][i] <= m_speed[k]) begin
              m_x[k][i] = m_x[k][i] + 720 - m_speed[k];
              m_g[k][i] = 80 + (m_lfsr[k] & 255);
            end else begin
              m_x[k][i] = m_x[k][i] - m_speed[k];
            end
          end
        end
        if (pass) begin
          m_head[k]  = (m_head[k] + 1) % 3;
          m_stick[k] = 1;
          if (m_score[k] < 255) m_score[k] = m_score[k] + 1;
        end
      end
    end else if (ak) begin
      model_init(k);
      m_st[k] = 0;
    end
    m_lfsr[k] = nl;
  endtask

  function automatic logic [51:0] exp_vec(input int k);
    int x, r, l;
    x = m_x[k][m_head[k]];
    r = (x > 1023) ? 1023 : x;
    l = (x >= 60) ? x - 60 : 0;
    if (l > 1023) l = 1023;
    return {10'(r), 10'(l), 10'(m_g[k][m_head[k]]), 10'(m_g[k][m_head[k]] + 120),
            8'(m_score[k]), 1'(m_stick[k]), m_st[k] == 0, m_st[k] == 1, m_st[k] == 2};
  endfunction

  task automatic cyc();
    @(posedge Clk);
    if (!reset_n) begin
      model_reset();
    end else begin
      model_clk(0, start_a, tick_a, lose_a, ack_a, int'(bird_a));
      model_clk(1, start_b, tick_b, lose_b, ack_b, int'(bird_b));
    end
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    model_reset();
    repeat (3) cyc();
    #2 reset_n = 1'b1;
    cyc();
    checks++; if (qi_a !== 1'b1) begin failures++; $display("FAIL reset_q_idle got=%b exp=1", qi_a); end
    checks++; if (xr_a !== 10'd700) begin failures++; $display("FAIL reset_x_right got=%0d exp=700", xr_a); end
    checks++; if (xl_a !== 10'd640) begin failures++; $display("FAIL reset_x_left got=%0d exp=640", xl_a); end
    checks++; if (yt_a !== 10'd180) begin failures++; $display("FAIL reset_y_top got=%0d exp=180", yt_a); end
    checks++; if (yb_a !== 10'd300) begin failures++; $display("FAIL reset_y_bottom got=%0d exp=300", yb_a); end
    checks++; if (score_a !== 8'd0) begin failures++; $display("FAIL reset_score got=%0d exp=0", score_a); end
    tick_a = 1'b1;
    repeat (3) begin
      cyc();
      checks++; if (act_a !== exp_vec(0)) begin failures++; $display("FAIL idle_tick got=%h exp=%h", act_a, exp_vec(0)); end
    end
    tick_a = 1'b0;
    checks++; if (xr_a !== 10'd700) begin failures++; $display("FAIL idle_tick_x_right got=%0d exp=700", xr_a); end
  endtask

  task automatic test_start_tick();
    start_a = 1'b1;
    cyc();
    start_a = 1'b0;
    checks++; if (qr_a !== 1'b1) begin failures++; $display("FAIL start_q_run got=%b exp=1", qr_a); end
    tick_a = 1'b1;
    cyc();
    tick_a = 1'b0;
    checks++; if (xr_a !== 10'd698) begin failures++; $display("FAIL first_tick_x_right got=%0d exp=698", xr_a); end
    checks++; if (xl_a !== 10'd638) begin failures++; $display("FAIL first_tick_x_left got=%0d exp=638", xl_a); end
  endtask

  task automatic test_pass();
    tick_a = 1'b1;
    repeat (300) begin
      cyc();
      checks++; if (act_a !== exp_vec(0)) begin failures++; $display("FAIL scroll got=%h exp=%h", act_a, exp_vec(0)); end
    end
    tick_a = 1'b0;
    checks++; if (xr_a !== 10'd98) begin failures++; $display("FAIL tick301_x_right got=%0d exp=98", xr_a); end
    cyc();
    checks++; if (score_a !== 8'd1) begin failures++; $display("FAIL pass_score got=%0d exp=1", score_a); end
    checks++; if (stick_a !== 1'b1) begin failures++; $display("FAIL pass_score_tick got=%b exp=1", stick_a); end
    checks++; if (xr_a !== 10'd338) begin failures++; $display("FAIL pass_x_right got=%0d exp=338", xr_a); end
    checks++; if (xl_a !== 10'd278) begin failures++; $display("FAIL pass_x_left got=%0d exp=278", xl_a); end
    cyc();
    checks++; if (stick_a !== 1'b0) begin failures++; $display("FAIL pass_tick_width got=%b exp=0", stick_a); end
  endtask

  task automatic test_respawn();
    int exp_gap;
    tick_a = 1'b1;
    repeat (48) begin
      cyc();
      checks++; if (act_a !== exp_vec(0)) begin failures++; $display("FAIL approach got=%h exp=%h", act_a, exp_vec(0)); end
      checks++; if (yb_a - yt_a !== 10'd120) begin failures++; $display("FAIL gap_height got=%0d exp=120", yb_a - yt_a); end
    end
    checks++; if (dut.r_xr[0] !== 11'd2) begin failures++; $display("FAIL tick349_slot0 got=%0d exp=2", dut.r_xr[0]); end
    exp_gap = 80 + (m_lfsr[0] & 255);
    cyc();
    tick_a = 1'b0;
    checks++; if (dut.r_xr[0] !== 11'd720) begin failures++; $display("FAIL tick350_slot0 got=%0d exp=720", dut.r_xr[0]); end
    checks++; if (dut.r_gt[0] !== 10'(exp_gap)) begin failures++; $display("FAIL respawn_gap got=%0d exp=%0d", dut.r_gt[0], exp_gap); end
    checks++; if (act_a !== exp_vec(0)) begin failures++; $display("FAIL respawn_outputs got=%h exp=%h", act_a, exp_vec(0)); end
  endtask

  task automatic test_lose();
    logic [39:0] edges;
    edges = act_a[51:12];
    tick_a = 1'b1;
    lose_a = 1'b1;
    cyc();
    lose_a = 1'b0;
    checks++; if (qf_a !== 1'b1) begin failures++; $display("FAIL lose_q_frozen got=%b exp=1", qf_a); end
    checks++; if (act_a[51:12] !== edges) begin failures++; $display("FAIL lose_edges got=%h exp=%h", act_a[51:12], edges); end
    repeat (3) begin
      cyc();
      checks++; if (act_a[51:12] !== edges) begin failures++; $display("FAIL frozen_tick got=%h exp=%h", act_a[51:12], edges); end
    end
    tick_a = 1'b0;
    ack_a = 1'b1;
    cyc();
    ack_a = 1'b0;
    checks++; if (qi_a !== 1'b1) begin failures++; $display("FAIL ack_q_idle got=%b exp=1", qi_a); end
    checks++; if (xr_a !== 10'd700) begin failures++; $display("FAIL ack_x_right got=%0d exp=700", xr_a); end
    checks++; if (score_a !== 8'd1) begin failures++; $display("FAIL ack_score_held got=%0d exp=1", score_a); end
    start_a = 1'b1;
    cyc();
    start_a = 1'b0;
    checks++; if (score_a !== 8'd0) begin failures++; $display("FAIL restart_score got=%0d exp=0", score_a); end
    checks++; if (act_a !== exp_vec(0)) begin failures++; $display("FAIL restart_outputs got=%h exp=%h", act_a, exp_vec(0)); end
  endtask

  task automatic test_random();
    repeat (800) begin
      tick_a  = 1'($urandom_range(0, 1));
      lose_a  = (m_st[0] == 1) && ($urandom_range(0, 149) == 0);
      ack_a   = ($urandom_range(0, 7) == 0);
      start_a = ($urandom_range(0, 3) == 0);
      if (m_st[0] == 0) bird_a = 10'($urandom_range(3, 400));
      cyc();
      checks++; if (act_a !== exp_vec(0)) begin failures++; $display("FAIL random got=%h exp=%h", act_a, exp_vec(0)); end
    end
    {tick_a, lose_a, ack_a, start_a} = 4'b0000;
  endtask

  task automatic test_async_reset();
    start_a = 1'b1;
    cyc();
    start_a = 1'b0;
    tick_a = 1'b1;
    repeat (10) cyc();
    tick_a = 1'b0;
    #3 reset_n = 1'b0;
    model_reset();
    #1;
    checks++; if (qi_a !== 1'b1) begin failures++; $display("FAIL async_q_idle got=%b exp=1", qi_a); end
    checks++; if (act_a !== exp_vec(0)) begin failures++; $display("FAIL async_outputs got=%h exp=%h", act_a, exp_vec(0)); end
    checks++; if (xr_a !== 10'd700) begin failures++; $display("FAIL async_x_right got=%0d exp=700", xr_a); end
    repeat (2) cyc();
    #3 reset_n = 1'b1;
    cyc();
    checks++; if (act_a !== exp_vec(0)) begin failures++; $display("FAIL post_reset got=%h exp=%h", act_a, exp_vec(0)); end
  endtask

  task automatic test_saturation();
    int sat_pulses;
    logic [7:0] prev_score;
    sat_pulses = 0;
    start_b = 1'b1;
    cyc();
    start_b = 1'b0;
    repeat (1000) begin
      tick_b = ($urandom_range(0, 3) != 0);
      prev_score = score_b;
      cyc();
      checks++; if (act_b !== exp_vec(1)) begin failures++; $display("FAIL sat_run got=%h exp=%h", act_b, exp_vec(1)); end
      if (prev_score == 8'd255 && stick_b === 1'b1) sat_pulses++;
    end
    tick_b = 1'b0;
    checks++; if (score_b !== 8'd255) begin failures++; $display("FAIL sat_score got=%0d exp=255", score_b); end
    checks++; if (sat_pulses == 0) begin failures++; $display("FAIL sat_pulse got=%0d exp=>0", sat_pulses); end
  endtask

  initial begin
    m_speed[0] = 2;
    m_speed[1] = 120;
    test_reset();
    test_start_tick();
    test_pass();
    test_respawn();
    test_lose();
    test_random();
    test_async_reset();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
